simple_dualportram_arbiter: RTL
===============================

Name: simple_dualportram_arbiter

Overview:
Two-requester arbiter that shares one simple_dualportram instance (one write port, one read port, 1-cycle registered read) between requesters A and B. Reads and writes are arbitrated independently, each with its own round-robin pointer, so one read and one write can issue in the same cycle. The block sits between two generated method blocks and the RAM. It registers all RAM-side controls and routes read data back to the requester that issued the read, tagged by a registered owner bit.

Parameters:
WIDTH, 32, data word width; must match the RAM's WIDTH
DEPTH, 10, address bits the RAM uses; upper address bits pass through unchanged

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
a_rreq  in  1  A read request; level, held until a_rack
a_raddr  in  32  A read address
a_rack  out  1  A read accepted (1-cycle pulse)
a_rvalid  out  1  A read data valid (1-cycle pulse)
a_rdata  out  WIDTH  A read data
a_wreq  in  1  A write request; level, held until a_wack
a_waddr  in  32  A write address
a_wdata  in  WIDTH  A write data
a_wack  out  1  A write accepted (1-cycle pulse)
b_rreq, b_raddr, b_rack, b_rvalid, b_rdata, b_wreq, b_waddr, b_wdata, b_wack  same as A, for requester B
ram_raddress  out  32  to RAM raddress_b
ram_waddress  out  32  to RAM waddress_b
ram_din  out  WIDTH  to RAM din_b
ram_we  out  1  to RAM we_b
ram_dout  in  WIDTH  from RAM dout_b

Behaviour:
- Reset (reset=0, asynchronous): all acks, rvalids and ram_we = 0; ram_raddress, ram_waddress and ram_din = 0; both round-robin pointers select A; read-owner tag = A. Outputs hold these values until the first rising edge after reset releases.
- Eligibility at edge k: a requester's read request counts only if its rreq=1 and its rack=0 during cycle k. A request seen while its ack is high is treated as already consumed. The same rule applies to writes.
- Read arbitration at edge k:
  - Exactly one requester eligible: grant it.
  - Both eligible: grant the requester the read pointer selects, then move the pointer to the other requester.
  - Single grant: set the pointer to the non-granted requester.
  - No eligible request: the pointer holds.
  - The write channel uses the same rules with its own pointer.
- Read grant at edge k, cycle k+1:
  - x_rack=1.
  - ram_raddress = granted raddr (registered).
  - A pipeline valid bit and the owner tag are registered.
- The RAM samples the address at edge k+1. In cycle k+2, x_rvalid=1 for the owner and x_rdata = ram_dout. Read latency from the request edge is 2 cycles.
- Outside rvalid, x_rdata still shows ram_dout, but its content is undefined.
- Write grant at edge k, cycle k+1: x_wack=1, ram_we=1, ram_waddress and ram_din registered from the granted requester. The RAM commits the write at edge k+1. ram_we is 0 in every cycle with no write grant. Address and data registers hold their last value.
- Throughput: each channel issues one grant per cycle. A single requester holding req high gets a grant on every other cycle. Alternating requesters fill every cycle.
- Read and write to the same address issued in the same cycle: the read returns the old data (RAM read-before-write).
- Read after write, same address: a read granted at edge k+1 or later after a write granted at edge k returns the new data.
- A requester may raise rreq and wreq together. The two are arbitrated independently and may both be acked in the same cycle.
- Dropping req before ack withdraws the request; no ack is produced.
- Reset asserted mid-operation clears any in-flight rvalid; no pulse is produced afterwards. Pointers return to A.
- Address bits above DEPTH-1 are passed through unchanged; the RAM ignores them, so they wrap modulo 2^DEPTH.

Test Plan:
- Reset with reset=0 while requests are high -> all acks, rvalid and ram_we = 0, ram addresses = 0. After release, the first contended read goes to A.
- A writes 0xDEADBEEF @5, then reads @5 -> wack in cycle 1, ram_we=1 with waddress=5. The read issued after the write ack gives a_rvalid 2 cycles after sampling, with a_rdata=0xDEADBEEF.
- A and B both hold rreq (A@1, B@2; mem[1]=0x11, mem[2]=0x22) -> rack order A, B, A, B on consecutive cycles. rvalid pulses alternate with 0x11/0x22, never both in one cycle.
- Same cycle: A writes 0x55 @7 (old 0x33) and B reads @7 -> both acked the same cycle; B gets 0x33. The next B read of @7 gets 0x55.
- B alone holds wreq high for 6 cycles -> b_wack pulses on alternate cycles (3 writes). Pointer behaviour then makes A win the next contention.
- Reset pulsed low in the cycle after a read ack -> no rvalid appears. The state matches the post-reset values.

Source files
------------

// File: rtl/simple_dualportram_arbiter_if.sv
// Bus bundle between two requesters, the arbiter and a simple dual-port RAM.
// The slave modport is the arbiter's view; master is the requester/RAM side.
interface simple_dualportram_arbiter_if #(
   parameter int WIDTH = 32
);
   logic             a_rreq;
   logic [31:0]      a_raddr;
   logic             a_rack;
   logic             a_rvalid;
   logic [WIDTH-1:0] a_rdata;
   logic             a_wreq;
   logic [31:0]      a_waddr;
   logic [WIDTH-1:0] a_wdata;
   logic             a_wack;

   logic             b_rreq;
   logic [31:0]      b_raddr;
   logic             b_rack;
   logic             b_rvalid;
   logic [WIDTH-1:0] b_rdata;
   logic             b_wreq;
   logic [31:0]      b_waddr;
   logic [WIDTH-1:0] b_wdata;
   logic             b_wack;

   logic [31:0]      ram_raddress;
   logic [31:0]      ram_waddress;
   logic [WIDTH-1:0] ram_din;
   logic             ram_we;
   logic [WIDTH-1:0] ram_dout;

   modport slave (
      input  a_rreq, a_raddr, a_wreq, a_waddr, a_wdata,
      input  b_rreq, b_raddr, b_wreq, b_waddr, b_wdata,
      input  ram_dout,
      output a_rack, a_rvalid, a_rdata, a_wack,
      output b_rack, b_rvalid, b_rdata, b_wack,
      output ram_raddress, ram_waddress, ram_din, ram_we
   );

   modport master (
      output a_rreq, a_raddr, a_wreq, a_waddr, a_wdata,
      output b_rreq, b_raddr, b_wreq, b_waddr, b_wdata,
      output ram_dout,
      input  a_rack, a_rvalid, a_rdata, a_wack,
      input  b_rack, b_rvalid, b_rdata, b_wack,
      input  ram_raddress, ram_waddress, ram_din, ram_we
   );
endinterface

// File: rtl/simple_dualportram_arbiter.sv
// Two-requester arbiter in front of one simple dual-port RAM; reads and writes
// each have their own round-robin pointer, and read data is steered by an owner tag.
module simple_dualportram_arbiter #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 10
) (
   input  logic                        clk,
   input  logic                        reset,
   simple_dualportram_arbiter_if.slave bus
);

   // Addresses are passed through at full width; the RAM uses only DEPTH bits.
   if (DEPTH > 32) begin : g_depth_exceeds_address_width
   end

   logic             rd_elig_a, rd_elig_b, rd_gnt_a, rd_gnt_b;
   logic             wr_elig_a, wr_elig_b, wr_gnt_a, wr_gnt_b;
   logic             rd_ptr_d, rd_ptr_q;
   logic             wr_ptr_d, wr_ptr_q;

   logic             a_rack_q, b_rack_q;
   logic             rd_pend_q, rd_own_q;
   logic             a_rvalid_q, b_rvalid_q;
   logic [31:0]      raddr_q;

   logic             a_wack_q, b_wack_q;
   logic             we_q;
   logic [31:0]      waddr_q;
   logic [WIDTH-1:0] din_q;

   // Pointer value 0 favours A, 1 favours B. A request seen while its ack is
   // high is the one just granted, so it is not eligible again.
   always_comb begin
      rd_elig_a = bus.a_rreq & ~a_rack_q;
      rd_elig_b = bus.b_rreq & ~b_rack_q;
      rd_gnt_a  = rd_elig_a & (~rd_elig_b | ~rd_ptr_q);
      rd_gnt_b  = rd_elig_b & (~rd_elig_a |  rd_ptr_q);
      rd_ptr_d  = rd_ptr_q;
      if (rd_gnt_a)      rd_ptr_d = 1'b1;
      else if (rd_gnt_b) rd_ptr_d = 1'b0;

      wr_elig_a = bus.a_wreq & ~a_wack_q;
      wr_elig_b = bus.b_wreq & ~b_wack_q;
      wr_gnt_a  = wr_elig_a & (~wr_elig_b | ~wr_ptr_q);
      wr_gnt_b  = wr_elig_b & (~wr_elig_a |  wr_ptr_q);
      wr_ptr_d  = wr_ptr_q;
      if (wr_gnt_a)      wr_ptr_d = 1'b1;
      else if (wr_gnt_b) wr_ptr_d = 1'b0;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rd_ptr_q   <= 1'b0;
         a_rack_q   <= 1'b0;
         b_rack_q   <= 1'b0;
         rd_pend_q  <= 1'b0;
         rd_own_q   <= 1'b0;
         a_rvalid_q <= 1'b0;
         b_rvalid_q <= 1'b0;
         raddr_q    <= '0;
      end else begin
         rd_ptr_q   <= rd_ptr_d;
         a_rack_q   <= rd_gnt_a;
         b_rack_q   <= rd_gnt_b;
         rd_pend_q  <= rd_gnt_a | rd_gnt_b;
         // RAM returns data one cycle after the address register loads.
         a_rvalid_q <= rd_pend_q & ~rd_own_q;
         b_rvalid_q <= rd_pend_q &  rd_own_q;
         if (rd_gnt_a) begin
            raddr_q  <= bus.a_raddr;
            rd_own_q <= 1'b0;
         end else if (rd_gnt_b) begin
            raddr_q  <= bus.b_raddr;
            rd_own_q <= 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr_q <= 1'b0;
         a_wack_q <= 1'b0;
         b_wack_q <= 1'b0;
         we_q     <= 1'b0;
         waddr_q  <= '0;
         din_q    <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         a_wack_q <= wr_gnt_a;
         b_wack_q <= wr_gnt_b;
         we_q     <= wr_gnt_a | wr_gnt_b;
         if (wr_gnt_a) begin
            waddr_q <= bus.a_waddr;
            din_q   <= bus.a_wdata;
         end else if (wr_gnt_b) begin
            waddr_q <= bus.b_waddr;
            din_q   <= bus.b_wdata;
         end
      end
   end

   assign bus.a_rack       = a_rack_q;
   assign bus.b_rack       = b_rack_q;
   assign bus.a_rvalid     = a_rvalid_q;
   assign bus.b_rvalid     = b_rvalid_q;
   assign bus.a_rdata      = bus.ram_dout;
   assign bus.b_rdata      = bus.ram_dout;
   assign bus.a_wack       = a_wack_q;
   assign bus.b_wack       = b_wack_q;
   assign bus.ram_raddress = raddr_q;
   assign bus.ram_waddress = waddr_q;
   assign bus.ram_din      = din_q;
   assign bus.ram_we       = we_q;

endmodule
